alarm_clock: RTL and testbench



---
 rtl/alarm_clock.sv | 145 ++++++++++++++
 tb/tb_alarm_clock.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alarm_clock.sv
// alarm_clock: minute-resolution 12-hour (by default) alarm clock.
//
// A prescaler divides the system clock into minute ticks that advance the
// current time. A programmable alarm, once armed, raises alarm_ringing for
// RING_CYCLES cycles on each rising edge of the time/alarm match.
//
// Ports:
//   clock          system clock, rising edge
//   reset          asynchronous, active-low; clears all state
//   set_time       level; loads hours/minutes into the current time if valid
//   set_alarm      level; loads alarm_hours/alarm_minutes and arms if valid
//   hours          [3:0] time hours to load
//   minutes        [5:0] time minutes to load
//   alarm_hours    [3:0] alarm hours to load
//   alarm_minutes  [5:0] alarm minutes to load
//   alarm_ringing  registered alarm indication for the buzzer driver
module alarm_clock #(
  parameter int TICKS_PER_MIN = 60,
  parameter int HOUR_MODULO   = 12,
  parameter int RING_CYCLES   = 4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       set_time,
  input  logic       set_alarm,
  input  logic [3:0] hours,
  input  logic [5:0] minutes,
  input  logic [3:0] alarm_hours,
  input  logic [5:0] alarm_minutes,
  output logic       alarm_ringing
);

  localparam int PW = (TICKS_PER_MIN > 1) ? $clog2(TICKS_PER_MIN) : 1;
  localparam int RW = $clog2(RING_CYCLES + 1);

  localparam logic [PW-1:0] PRE_LAST   = PW'(TICKS_PER_MIN - 1);
  localparam logic [PW-1:0] PRE_ONE    = PW'(1);
  localparam logic [3:0]    HOUR_LAST  = 4'(HOUR_MODULO - 1);
  localparam logic [4:0]    HOUR_LIMIT = 5'(HOUR_MODULO);
  localparam logic [RW-1:0] RING_INIT  = RW'(RING_CYCLES - 1);
  localparam logic [RW-1:0] RING_ONE   = RW'(1);

  function automatic logic time_valid(input logic [3:0] h, input logic [5:0] m);
    return ({1'b0, h} < HOUR_LIMIT) && (m < 6'd60);
  endfunction

  logic [3:0]    cur_h_q, cur_h_d;
  logic [5:0]    cur_m_q, cur_m_d;
  logic [PW-1:0] prescale_q, prescale_d;
  logic [3:0]    alm_h_q, alm_h_d;
  logic [5:0]    alm_m_q, alm_m_d;
  logic          armed_q, armed_d;
  // Previous-cycle value of match, used for rising-edge detection.
  logic          match_prev_q, match_prev_d;
  logic [RW-1:0] ring_cnt_q, ring_cnt_d;
  logic          ringing_q, ringing_d;

  logic time_load;
  logic alarm_load;
  logic match;
  logic trigger;

  always_comb begin
    time_load  = set_time && time_valid(hours, minutes);
    alarm_load = set_alarm && time_valid(alarm_hours, alarm_minutes);
    match      = armed_q && (cur_h_q == alm_h_q) && (cur_m_q == alm_m_q);
    // An alarm load in progress suppresses triggering; the match it creates
    // fires on the following edge once set_alarm is released.
    trigger    = match && !match_prev_q && !alarm_load;
  end

  // Timekeeping: a valid set_time wins over the minute tick.
  always_comb begin
    cur_h_d    = cur_h_q;
    cur_m_d    = cur_m_q;
    prescale_d = prescale_q + PRE_ONE;
    if (time_load) begin
      cur_h_d    = hours;
      cur_m_d    = minutes;
      prescale_d = '0;
    end else if (prescale_q == PRE_LAST) begin
      prescale_d = '0;
      if (cur_m_q == 6'd59) begin
        cur_m_d = 6'd0;
        cur_h_d = (cur_h_q == HOUR_LAST) ? 4'd0 : cur_h_q + 4'd1;
      end else begin
        cur_m_d = cur_m_q + 6'd1;
      end
    end
  end

  // Alarm registers and ring sequencer.
  always_comb begin
    alm_h_d      = alm_h_q;
    alm_m_d      = alm_m_q;
    armed_d      = armed_q;
    match_prev_d = match;
    ring_cnt_d   = ring_cnt_q;
    ringing_d    = ringing_q;
    if (alarm_load) begin
      alm_h_d    = alarm_hours;
      alm_m_d    = alarm_minutes;
      armed_d    = 1'b1;
      ringing_d  = 1'b0;
      ring_cnt_d = '0;
    end else if (trigger) begin
      // Also covers a re-trigger while ringing: the count restarts.
      ringing_d  = 1'b1;
      ring_cnt_d = RING_INIT;
    end else if (ringing_q) begin
      if (ring_cnt_q == '0) begin
        ringing_d = 1'b0;
      end else begin
        ring_cnt_d = ring_cnt_q - RING_ONE;
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cur_h_q      <= '0;
      cur_m_q      <= '0;
      prescale_q   <= '0;
      alm_h_q      <= '0;
      alm_m_q      <= '0;
      armed_q      <= 1'b0;
      match_prev_q <= 1'b0;
      ring_cnt_q   <= '0;
      ringing_q    <= 1'b0;
    end else begin
      cur_h_q      <= cur_h_d;
      cur_m_q      <= cur_m_d;
      prescale_q   <= prescale_d;
      alm_h_q      <= alm_h_d;
      alm_m_q      <= alm_m_d;
      armed_q      <= armed_d;
      match_prev_q <= match_prev_d;
      ring_cnt_q   <= ring_cnt_d;
      ringing_q    <= ringing_d;
    end
  end

  assign alarm_ringing = ringing_q;

endmodule

// File: tb/tb_alarm_clock.sv
// Directed testbench for alarm_clock with default parameters
// (60 ticks per minute, 12 hours, 4 ring cycles).
// Inputs change just after the falling edge; alarm_ringing is sampled on the
// falling edge, so "after edge N" means the negedge following posedge N.
module tb_alarm_clock;

  logic       clock;
  logic       reset;
  logic       set_time;
  logic       set_alarm;
  logic [3:0] hours;
  logic [5:0] minutes;
  logic [3:0] alarm_hours;
  logic [5:0] alarm_minutes;
  logic       alarm_ringing;

  int tests;
  int fails;

  alarm_clock dut (
    .clock         (clock),
    .reset         (reset),
    .set_time      (set_time),
    .set_alarm     (set_alarm),
    .hours         (hours),
    .minutes       (minutes),
    .alarm_hours   (alarm_hours),
    .alarm_minutes (alarm_minutes),
    .alarm_ringing (alarm_ringing)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // One-cycle set_time pulse; returns just after the load edge.
  task automatic load_time(input logic [3:0] h, input logic [5:0] m);
    set_time = 1'b1;
    hours    = h;
    minutes  = m;
    @(negedge clock);
    set_time = 1'b0;
  endtask

  // One-cycle set_alarm pulse; returns just after the load edge.
  task automatic load_alarm(input logic [3:0] h, input logic [5:0] m);
    set_alarm     = 1'b1;
    alarm_hours   = h;
    alarm_minutes = m;
    @(negedge clock);
    set_alarm = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clock);
    tests++;
    if (alarm_ringing !== 1'b0) begin
      fails++;
      $display("FAIL reset_held ringing=%b expected=0", alarm_ringing);
    end
    reset = 1'b1;
    @(negedge clock);
    tests++;
    if (alarm_ringing !== 1'b0) begin
      fails++;
      $display("FAIL reset_release ringing=%b expected=0", alarm_ringing);
    end
  endtask

  task automatic test_idle();
    int hi;
    hi = 0;
    repeat (3600) begin
      @(negedge clock);
      if (alarm_ringing) hi++;
    end
    tests++;
    if (hi !== 0) begin
      fails++;
      $display("FAIL idle_unarmed high_cycles=%0d expected=0", hi);
    end
  endtask

  task automatic test_match_set_time();
    logic exp;
    load_alarm(4'd9, 6'd46);
    load_time(4'd9, 6'd46);
    for (int i = 0; i < 6; i++) begin
      if (i > 0) @(negedge clock);
      exp = (i >= 1) && (i <= 4);
      tests++;
      if (alarm_ringing !== exp) begin
        fails++;
        $display("FAIL match_set_time cycle=%0d ringing=%b expected=%b", i, alarm_ringing, exp);
      end
    end
  endtask

  task automatic test_match_tick();
    logic exp;
    load_alarm(4'd6, 6'd27);
    load_time(4'd6, 6'd26);
    for (int k = 0; k <= 66; k++) begin
      if (k > 0) @(negedge clock);
      exp = (k >= 61) && (k <= 64);
      tests++;
      if (alarm_ringing !== exp) begin
        fails++;
        $display("FAIL match_tick cycle=%0d ringing=%b expected=%b", k, alarm_ringing, exp);
      end
    end
  endtask

  task automatic test_invalid_load();
    logic exp;
    load_time(4'd2, 6'd10);
    load_time(4'd15, 6'd10);
    load_time(4'd2, 6'd62);
    // Alarm matches the (unchanged) time: rings one edge after the load.
    load_alarm(4'd2, 6'd10);
    tests++;
    if (alarm_ringing !== 1'b0) begin
      fails++;
      $display("FAIL invalid_time_load_edge ringing=%b expected=0", alarm_ringing);
    end
    @(negedge clock);
    tests++;
    if (alarm_ringing !== 1'b1) begin
      fails++;
      $display("FAIL invalid_time_kept ringing=%b expected=1", alarm_ringing);
    end
    // Invalid alarm load during ringing must not cancel it.
    load_alarm(4'd13, 6'd10);
    for (int i = 2; i <= 5; i++) begin
      if (i > 2) @(negedge clock);
      exp = (i <= 4);
      tests++;
      if (alarm_ringing !== exp) begin
        fails++;
        $display("FAIL invalid_alarm_ring cycle=%0d ringing=%b expected=%b", i, alarm_ringing, exp);
      end
    end
    // Alarm must still be 2:10: leave and return to that time.
    load_time(4'd5, 6'd0);
    load_time(4'd2, 6'd10);
    tests++;
    if (alarm_ringing !== 1'b0) begin
      fails++;
      $display("FAIL invalid_alarm_rematch_edge ringing=%b expected=0", alarm_ringing);
    end
    @(negedge clock);
    tests++;
    if (alarm_ringing !== 1'b1) begin
      fails++;
      $display("FAIL invalid_alarm_kept ringing=%b expected=1", alarm_ringing);
    end
    repeat (5) @(negedge clock);
  endtask

  task automatic test_back_to_back();
    logic exp;
    load_alarm(4'd8, 6'd0);
    set_time = 1'b1;
    hours    = 4'd8;
    minutes  = 6'd0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clock);
      if (i == 0) minutes = 6'd1;
      else if (i == 1) minutes = 6'd0;
      else set_time = 1'b0;
      exp = (i >= 1) && (i <= 6);
      tests++;
      if (alarm_ringing !== exp) begin
        fails++;
        $display("FAIL retrigger cycle=%0d ringing=%b expected=%b", i, alarm_ringing, exp);
      end
    end
  endtask

  task automatic test_async_reset_and_invalid_arm();
    load_alarm(4'd5, 6'd5);
    load_time(4'd5, 6'd5);
    @(negedge clock);
    tests++;
    if (alarm_ringing !== 1'b1) begin
      fails++;
      $display("FAIL async_pre ringing=%b expected=1", alarm_ringing);
    end
    #2 reset = 1'b0;
    #1;
    tests++;
    if (alarm_ringing !== 1'b0) begin
      fails++;
      $display("FAIL async_reset ringing=%b expected=0", alarm_ringing);
    end
    @(negedge clock);
    reset = 1'b1;
    // After reset time and alarm are both 0:00; only armed keeps them apart.
    load_alarm(4'd13, 6'd0);
    for (int i = 0; i < 6; i++) begin
      if (i > 0) @(negedge clock);
      tests++;
      if (alarm_ringing !== 1'b0) begin
        fails++;
        $display("FAIL invalid_arm cycle=%0d ringing=%b expected=0", i, alarm_ringing);
      end
    end
  endtask

  task automatic test_cancel();
    load_alarm(4'd4, 6'd20);
    load_time(4'd4, 6'd20);
    @(negedge clock);
    tests++;
    if (alarm_ringing !== 1'b1) begin
      fails++;
      $display("FAIL cancel_pre ringing=%b expected=1", alarm_ringing);
    end
    set_alarm     = 1'b1;
    alarm_hours   = 4'd11;
    alarm_minutes = 6'd55;
    set_time      = 1'b1;
    hours         = 4'd4;
    minutes       = 6'd20;
    @(negedge clock);
    set_alarm = 1'b0;
    tests++;
    if (alarm_ringing !== 1'b0) begin
      fails++;
      $display("FAIL cancel_drop ringing=%b expected=0", alarm_ringing);
    end
    for (int i = 0; i < 8; i++) begin
      @(negedge clock);
      tests++;
      if (alarm_ringing !== 1'b0) begin
        fails++;
        $display("FAIL cancel_hold cycle=%0d ringing=%b expected=0", i, alarm_ringing);
      end
    end
    set_time = 1'b0;
  endtask

  task automatic test_hold_alarm();
    load_time(4'd7, 6'd0);
    set_alarm     = 1'b1;
    alarm_hours   = 4'd7;
    alarm_minutes = 6'd0;
    for (int i = 0; i < 11; i++) begin
      @(negedge clock);
      if (i == 4) set_alarm = 1'b0;
      tests++;
      if (alarm_ringing !== 1'b0) begin
        fails++;
        $display("FAIL hold_alarm cycle=%0d ringing=%b expected=0", i, alarm_ringing);
      end
    end
  endtask

  task automatic test_wrap();
    logic exp;
    load_alarm(4'd0, 6'd0);
    load_time(4'd11, 6'd59);
    for (int k = 0; k <= 66; k++) begin
      if (k > 0) @(negedge clock);
      exp = (k >= 61) && (k <= 64);
      tests++;
      if (alarm_ringing !== exp) begin
        fails++;
        $display("FAIL wrap cycle=%0d ringing=%b expected=%b", k, alarm_ringing, exp);
      end
    end
  endtask

  task automatic test_simultaneous();
    logic exp;
    load_time(4'd1, 6'd0);
    set_time      = 1'b1;
    hours         = 4'd3;
    minutes       = 6'd33;
    set_alarm     = 1'b1;
    alarm_hours   = 4'd3;
    alarm_minutes = 6'd33;
    @(negedge clock);
    set_time  = 1'b0;
    set_alarm = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (i > 0) @(negedge clock);
      exp = (i >= 1) && (i <= 4);
      tests++;
      if (alarm_ringing !== exp) begin
        fails++;
        $display("FAIL simultaneous cycle=%0d ringing=%b expected=%b", i, alarm_ringing, exp);
      end
    end
  endtask

  initial begin
    tests         = 0;
    fails         = 0;
    reset         = 1'b0;
    set_time      = 1'b0;
    set_alarm     = 1'b0;
    hours         = 4'd0;
    minutes       = 6'd0;
    alarm_hours   = 4'd0;
    alarm_minutes = 6'd0;
    test_reset();
    test_idle();
    test_match_set_time();
    test_match_tick();
    test_invalid_load();
    test_back_to_back();
    test_async_reset_and_invalid_arm();
    test_cancel();
    test_hold_alarm();
    test_wrap();
    test_simultaneous();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
